// File: rtl/yasu_draw_ctrl_pkg.sv
// Shared constants for the yasu sprite redraw controller: screen and
// sprite geometry, background colour, reset position and FSM states.
package yasu_draw_ctrl_pkg;

    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam int Y_OFS = 9;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    localparam logic [2:0] BG_COLOUR = 3'b111;
    localparam logic [7:0] INIT_X    = 8'd72;
    localparam logic [6:0] INIT_Y    = 7'd100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/yasu_draw_ctrl_box_sweep_counter.sv
// Raster counter over one sprite box: cx is the inner (column) count,
// cy the outer (row) count.
// Ports: clk, reset (sync, high), clr (restart at 0,0), en (advance),
//        cx/cy (current pixel within box), last (cx,cy at final pixel).
module yasu_draw_ctrl_box_sweep_counter
    import yasu_draw_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic       last
);

    localparam logic [3:0] CX_MAX = 4'(SPR_W - 1);
    localparam logic [3:0] CY_MAX = 4'(SPR_H - 1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (cx == CX_MAX) begin
                cx <= '0;
                cy <= (cy == CY_MAX) ? '0 : cy + 4'd1;
            end else begin
                cx <= cx + 4'd1;
            end
        end
    end

    assign last = (cx == CX_MAX) && (cy == CY_MAX);

endmodule

// File: rtl/yasu_draw_ctrl.sv
// Redraws the player sprite: erases the old box in background colour,
// then sweeps the new box querying the external character block.
// Ports: clk, reset (sync, high); frame_start/new_x/new_y request in;
//        char_* query to character, char_color back; vga_* write port
//        (registered); busy while redrawing, done one-cycle completion.
module yasu_draw_ctrl
    import yasu_draw_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    output logic [7:0] char_x,
    output logic [6:0] char_y,
    output logic [7:0] char_yasu_x,
    output logic [6:0] char_yasu_y,
    input  logic [2:0] char_color,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nx;
    logic [7:0] cur_x, nxt_x;
    logic [6:0] cur_y, nxt_y;
    logic       first_flag;

    logic [3:0] cx, cy;
    logic       last, cnt_clr, cnt_en;

    logic [7:0] anc_x;
    logic [6:0] anc_y;
    logic [8:0] px;
    logic [8:0] py;
    logic       on_screen, plot_d;
    logic [2:0] colour_d;

    yasu_draw_ctrl_box_sweep_counter u_sweep (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cx    (cx),
        .cy    (cy),
        .last  (last)
    );

    // py is two's complement in 9 bits so rows above the screen stay
    // negative instead of wrapping onto the bottom edge.
    always_comb begin
        anc_x     = (state == ERASE) ? cur_x : nxt_x;
        anc_y     = (state == ERASE) ? cur_y : nxt_y;
        px        = {1'b0, anc_x} + {5'b0, cx};
        py        = {2'b0, anc_y} + {5'b0, cy} - 9'(Y_OFS);
        on_screen = (px < 9'(SCR_W)) && !py[8] && (py < 9'(SCR_H));
        plot_d    = ((state == ERASE) || (state == DRAW)) && on_screen;
        colour_d  = (state == DRAW) ? char_color : BG_COLOUR;
    end

    assign char_x      = (state == DRAW) ? px[7:0] : 8'd0;
    assign char_y      = (state == DRAW) ? py[6:0] : 7'd0;
    assign char_yasu_x = nxt_x;
    assign char_yasu_y = nxt_y;

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (frame_start)
                    state_nx = first_flag ? DRAW : ERASE;
            end
            ERASE: begin
                cnt_en = 1'b1;
                if (last) begin
                    state_nx = DRAW;
                    cnt_clr  = 1'b1;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                if (last)
                    state_nx = FIN;
            end
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_x      <= INIT_X;
            cur_y      <= INIT_Y;
            nxt_x      <= INIT_X;
            nxt_y      <= INIT_Y;
            first_flag <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state      <= state_nx;
            done       <= (state == FIN);
            vga_x      <= px[7:0];
            vga_y      <= py[6:0];
            vga_colour <= colour_d;
            vga_plot   <= plot_d;
            if ((state == IDLE) && frame_start) begin
                nxt_x <= new_x;
                nxt_y <= new_y;
                busy  <= 1'b1;
            end
            if (state == FIN) begin
                cur_x      <= nxt_x;
                cur_y      <= nxt_y;
                first_flag <= 1'b0;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_yasu_draw_ctrl.sv
// Self-checking bench for yasu_draw_ctrl: a list-of-writes reference
// model per redraw, compared write by write against the VGA port.
module tb_yasu_draw_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic [7:0] char_x;
    logic [6:0] char_y;
    logic [7:0] char_yasu_x;
    logic [6:0] char_yasu_y;
    logic [2:0] char_color;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } wr_t;

    logic [7:0] m_cur_x;
    logic [6:0] m_cur_y;
    bit         m_first;

    always #5 clk = ~clk;

    yasu_draw_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .new_x       (new_x),
        .new_y       (new_y),
        .char_x      (char_x),
        .char_y      (char_y),
        .char_yasu_x (char_yasu_x),
        .char_yasu_y (char_yasu_y),
        .char_color  (char_color),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [2:0] char_model(input int px, input int py,
                                              input int ax, input int ay);
        int v;
        v = (px * 3) ^ (py * 5) ^ ax ^ (ay * 7);
        return 3'(v & 7);
    endfunction

    assign char_color = char_model(int'(char_x), int'(char_y),
                                   int'(char_yasu_x), int'(char_yasu_y));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void add_box(ref wr_t q[$], input int ax,
                                    input int ay, input bit erase);
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++) begin
                int px;
                int py;
                wr_t w;
                px = ax + xx;
                py = ay + yy - 9;
                if (px < 160 && py >= 0 && py < 120) begin
                    w.x = 8'(px);
                    w.y = 7'(py);
                    w.c = erase ? 3'b111 : char_model(px, py, ax, ay);
                    q.push_back(w);
                end
            end
    endfunction

    task automatic run_frame(input logic [7:0] nx, input logic [6:0] ny,
                             input int rp_at);
        wr_t exp_q[$];
        wr_t obs_q[$];
        int  lat;
        int  got_n;
        if (!m_first)
            add_box(exp_q, int'(m_cur_x), int'(m_cur_y), 1'b1);
        add_box(exp_q, int'(nx), int'(ny), 1'b0);
        lat   = m_first ? 258 : 514;
        got_n = -1;
        @(negedge clk);
        frame_start = 1'b1;
        new_x = nx;
        new_y = ny;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_start", int'(busy), 1);
        for (int n = 1; n <= 600; n++) begin
            if (n > 1) @(negedge clk);
            frame_start = (n == rp_at);
            new_x = 8'($urandom);
            new_y = 7'($urandom);
            if (vga_plot) obs_q.push_back({vga_x, vga_y, vga_colour});
            if (done) begin
                got_n = n;
                break;
            end
        end
        frame_start = 1'b0;
        chk("done_lat", got_n, lat);
        chk("busy_done", int'(busy), 0);
        chk("nplots", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] != exp_q[i]) begin
                chk("wr_x", int'(obs_q[i].x), int'(exp_q[i].x));
                chk("wr_y", int'(obs_q[i].y), int'(exp_q[i].y));
                chk("wr_c", int'(obs_q[i].c), int'(exp_q[i].c));
                break;
            end
        end
        @(negedge clk);
        chk("done_once", int'(done), 0);
        chk("plot_idle", int'(vga_plot), 0);
        m_cur_x = nx;
        m_cur_y = ny;
        m_first = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        new_x = '0;
        new_y = '0;
        m_cur_x = 8'd72;
        m_cur_y = 7'd100;
        m_first = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);

        frame_start = 1'b1;
        new_x = 8'd10;
        new_y = 7'd20;
        @(negedge clk);
        reset = 1'b0;
        frame_start = 1'b0;
        chk("rst_fs_busy", int'(busy), 0);
        @(negedge clk);
        chk("rst_fs_busy2", int'(busy), 0);
        chk("rst_fs_plot", int'(vga_plot), 0);

        run_frame(8'd72, 7'd100, 0);
        run_frame(8'd80, 7'd100, 0);
        run_frame(8'd150, 7'd5, 0);
        run_frame(8'd40, 7'd60, 100);
        run_frame(8'd40, 7'd60, 0);

        @(negedge clk);
        frame_start = 1'b1;
        new_x = 8'd20;
        new_y = 7'd30;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (299) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_plot", int'(vga_plot), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        m_cur_x = 8'd72;
        m_cur_y = 7'd100;
        m_first = 1'b1;
        run_frame(8'd100, 7'd50, 0);

        run_frame(8'd0, 7'd0, 0);
        run_frame(8'd255, 7'd127, 0);
        for (int k = 0; k < 10; k++) begin
            logic [7:0] rx;
            logic [6:0] ry;
            int         rp;
            rx = 8'($urandom_range(0, 255));
            ry = 7'($urandom_range(0, 127));
            rp = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 250) : 0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_frame(rx, ry, rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
